// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the memory/IO responder on the cpu byte bus.
// Holds the IO window map, the stop-FSM state encoding, the byte type and
// a byte-lane helper used when reading the cycle-counter snapshot.
package mem_io_responder_pkg;

  localparam logic [17:0] IO_BASE     = 18'h30000;
  localparam logic [17:0] IO_UART_OFF = 18'd0;
  localparam logic [17:0] IO_CLK_OFF  = 18'd4;

  typedef logic [7:0] BYTE_TP;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2,
    ST_HALT  = 2'd3
  } stop_state_e;

  function automatic BYTE_TP lane_sel(input logic [31:0] word, input logic [1:0] lane);
    BYTE_TP res;
    case (lane)
      2'd0:    res = word[7:0];
      2'd1:    res = word[15:8];
      2'd2:    res = word[23:16];
      default: res = word[31:24];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_io_responder_sync_fifo.sv
// Byte-wide synchronous FIFO with enable, count and next-count outputs.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset (pointers/count)
//   en_i              global enable; when low nothing moves
//   push_i, data_i    push request and byte
//   pop_i             pop request (ignored when empty)
//   data_o            head byte (0 when empty)
//   empty_o, full_o   status
//   count_o           current occupancy
//   count_next_o      occupancy after this cycle's accepted push/pop
//   push_ok_o         push accepted this cycle
module mem_io_responder_sync_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          push_i,
  input  BYTE_TP        data_i,
  input  logic          pop_i,
  output BYTE_TP        data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   count_o,
  output logic [AW:0]   count_next_o,
  output logic          push_ok_o
);

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  BYTE_TP        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign pop_ok  = en_i && pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = en_i && push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o       = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign push_ok_o    = push_ok;

endmodule

// File: rtl/mem_io_responder.sv
// Far end of the cpu byte-wide memory bus: RAM plus an IO window at
// mem_a[17:16]==2'b11 with a UART TX FIFO, an RX holding byte, a free-running
// cycle counter (read by byte lanes through a snapshot) and a stop flag.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rdy                 global ready; low freezes all state
//   mem_a/mem_dout/mem_wr  cpu address, write data, write strobe
//   mem_din             read data, valid the cycle after the address
//   io_buffer_full      TX FIFO holds DEPTH-1 or more bytes
//   tx_valid/tx_data/tx_ready  TX FIFO head handshake to the UART
//   rx_valid/rx_data    incoming byte strobe
//   prog_done           one-cycle pulse once stop is requested and TX drained
//   txq_ovf             sticky: a TX byte was dropped on a full FIFO
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW    = 17,
  parameter int TXQ_DEPTH = 8,
  parameter int TXQ_AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        prog_done,
  output logic        txq_ovf
);

  localparam logic [17:0] UART_ADDR = IO_BASE + IO_UART_OFF;
  localparam logic [17:0] CLK_ADDR  = IO_BASE + IO_CLK_OFF;
  localparam int          NF        = TXQ_DEPTH - 1;
  localparam logic [TXQ_AW:0] NEAR_FULL = NF[TXQ_AW:0];

  // Address decode
  logic [17:0] a18;
  logic        unused_a_hi;
  logic        io_sel, ram_we, ram_re, io_rd, io_wr;
  logic        uart_hit, clk_hit;
  logic [1:0]  lane;

  assign a18         = mem_a[17:0];
  assign unused_a_hi = ^mem_a[31:18];
  assign io_sel      = (a18[17:16] == 2'b11);
  assign ram_we      = mem_wr && !io_sel;
  assign ram_re      = !mem_wr && !io_sel;
  assign io_wr       = mem_wr && io_sel;
  assign io_rd       = !mem_wr && io_sel;
  assign uart_hit    = (a18 == UART_ADDR);
  assign clk_hit     = (a18[17:2] == CLK_ADDR[17:2]);
  assign lane        = a18[1:0];

  // RAM: synchronous read, no reset on contents
  BYTE_TP ram_q [2**RAM_AW];
  BYTE_TP ram_rdata_q;

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (ram_we)      ram_q[mem_a[RAM_AW-1:0]] <= mem_dout;
      else if (ram_re) ram_rdata_q <= ram_q[mem_a[RAM_AW-1:0]];
    end
  end

  // TX FIFO
  logic            txq_push_req, txq_push_ok, txq_empty, txq_full;
  logic [TXQ_AW:0] txq_count_next, unused_txq_count;
  BYTE_TP          txq_head;

  assign txq_push_req = io_wr && uart_hit && (mem_dout != 8'h00);

  mem_io_responder_sync_fifo #(
    .DEPTH (TXQ_DEPTH),
    .AW    (TXQ_AW)
  ) u_txq (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (rdy),
    .push_i       (txq_push_req),
    .data_i       (mem_dout),
    .pop_i        (tx_ready),
    .data_o       (txq_head),
    .empty_o      (txq_empty),
    .full_o       (txq_full),
    .count_o      (unused_txq_count),
    .count_next_o (txq_count_next),
    .push_ok_o    (txq_push_ok)
  );

  assign tx_valid = !txq_empty;
  assign tx_data  = txq_head;

  // IO read path, RX holding register, counter, overflow flag
  logic        sel_ram_q, sel_ram_d;
  BYTE_TP      io_rdata_q, io_rdata_d;
  logic        rx_full_q, rx_full_d;
  BYTE_TP      rx_byte_q;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] snap_q;
  logic        ovf_q, ovf_d;
  logic        buf_full_q, buf_full_d;

  always_comb begin
    sel_ram_d  = sel_ram_q;
    io_rdata_d = io_rdata_q;
    rx_full_d  = rx_full_q;
    cyc_d      = cyc_q + 32'd1;
    ovf_d      = ovf_q;
    buf_full_d = (txq_count_next >= NEAR_FULL);
    if (ram_re) begin
      sel_ram_d = 1'b1;
    end else if (io_rd) begin
      sel_ram_d = 1'b0;
      if (uart_hit) begin
        io_rdata_d = rx_full_q ? rx_byte_q : 8'h00;
        rx_full_d  = 1'b0;
      end else if (clk_hit) begin
        // Lane 0 returns the live count and captures it for lanes 1..3.
        io_rdata_d = (lane == 2'd0) ? cyc_q[7:0] : lane_sel(snap_q, lane);
      end else begin
        io_rdata_d = 8'h00;
      end
    end
    // A byte arriving alongside the UART read lands after the old one is returned.
    if (rx_valid) rx_full_d = 1'b1;
    if (txq_push_req && !txq_push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_ram_q  <= 1'b0;
      io_rdata_q <= '0;
      rx_full_q  <= 1'b0;
      cyc_q      <= '0;
      ovf_q      <= 1'b0;
      buf_full_q <= 1'b0;
    end else if (rdy) begin
      sel_ram_q  <= sel_ram_d;
      io_rdata_q <= io_rdata_d;
      rx_full_q  <= rx_full_d;
      cyc_q      <= cyc_d;
      ovf_q      <= ovf_d;
      buf_full_q <= buf_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rx_valid) rx_byte_q <= rx_data;
      if (io_rd && clk_hit && (lane == 2'd0)) snap_q <= cyc_q;
    end
  end

  assign mem_din        = sel_ram_q ? ram_rdata_q : io_rdata_q;
  assign io_buffer_full = buf_full_q;
  assign txq_ovf        = ovf_q;

  // Stop FSM
  stop_state_e st_q, st_d;
  logic        stop_wr;

  assign stop_wr = io_wr && (a18 == CLK_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (rdy) begin
      case (st_q)
        ST_IDLE:  if (stop_wr) st_d = ST_DRAIN;
        ST_DRAIN: if (txq_empty && !txq_push_ok) st_d = ST_DONE;
        ST_DONE:  st_d = ST_HALT;
        default:  st_d = st_q;
      endcase
    end
  end

  assign prog_done = (st_q == ST_DONE);

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic [31:0] mem_a = 32'h0003000C;
  logic [7:0]  mem_dout = 8'h00;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        prog_done;
  logic        txq_ovf;

  int n_chk  = 0;
  int n_pass = 0;

  mem_io_responder dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .prog_done      (prog_done),
    .txq_ovf        (txq_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One bus cycle, then return the bus to a harmless IO read of an unmapped address.
  task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
    mem_a = a; mem_wr = wr; mem_dout = d;
    tick();
    mem_a = 32'h0003000C; mem_wr = 1'b0; mem_dout = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] popped [$];
    logic [7:0] exp_q  [$];
    int idx_empty, idx_done, pulses;

    // Reset state
    @(negedge clk);
    tick();
    chk("rst_mem_din", {24'h0, mem_din}, 32'h0);
    chk("rst_iobf", {31'h0, io_buffer_full}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_prog_done", {31'h0, prog_done}, 32'h0);
    chk("rst_ovf", {31'h0, txq_ovf}, 32'h0);
    rst = 1'b0;

    // Cycle counter: 100 rdy cycles, then lane reads and an rdy freeze
    for (int i = 0; i < 100; i++) tick();
    bus(32'h00030004, 1'b0, 8'h00);
    chk("clk_lane0", {24'h0, mem_din}, 32'h64);
    rdy = 1'b0;
    mem_a = 32'h00030005;
    for (int i = 0; i < 10; i++) tick();
    chk("clk_hold_rdy0", {24'h0, mem_din}, 32'h64);
    rdy = 1'b1;
    bus(32'h00030005, 1'b0, 8'h00);
    chk("clk_lane1", {24'h0, mem_din}, 32'h00);
    bus(32'h00030006, 1'b0, 8'h00);
    chk("clk_lane2", {24'h0, mem_din}, 32'h00);
    bus(32'h00030007, 1'b0, 8'h00);
    chk("clk_lane3", {24'h0, mem_din}, 32'h00);
    bus(32'h00030004, 1'b0, 8'h00);
    chk("clk_relane0", {24'h0, mem_din}, 32'h68);

    // RAM
    bus(32'h00000010, 1'b1, 8'hA5);
    bus(32'h00000010, 1'b0, 8'h00);
    chk("ram_rd_10", {24'h0, mem_din}, 32'hA5);
    bus(32'h0001FFFF, 1'b1, 8'h3C);
    bus(32'h0001FFFF, 1'b0, 8'h00);
    chk("ram_rd_1ffff", {24'h0, mem_din}, 32'h3C);
    bus(32'h00030008, 1'b0, 8'h00);
    chk("io_unmapped", {24'h0, mem_din}, 32'h00);
    bus(32'hFFFC0010, 1'b0, 8'h00);
    chk("ram_alias_hi", {24'h0, mem_din}, 32'hA5);

    // RX holding register
    rx_valid = 1'b1; rx_data = 8'h37;
    tick();
    rx_valid = 1'b0;
    bus(32'h00030000, 1'b0, 8'h00);
    chk("rx_first", {24'h0, mem_din}, 32'h37);
    bus(32'h00030000, 1'b0, 8'h00);
    chk("rx_second", {24'h0, mem_din}, 32'h00);
    rx_valid = 1'b1; rx_data = 8'h55;
    bus(32'h00030000, 1'b0, 8'h00);
    rx_valid = 1'b0;
    chk("rx_same_cycle_old", {24'h0, mem_din}, 32'h00);
    bus(32'h00030000, 1'b0, 8'h00);
    chk("rx_same_cycle_new", {24'h0, mem_din}, 32'h55);

    // TX stream with a zero byte in the middle
    do_reset();
    tx_ready = 1'b1;
    popped.delete();
    bus(32'h00030000, 1'b1, 8'h48); if (tx_valid) popped.push_back(tx_data);
    bus(32'h00030000, 1'b1, 8'h69); if (tx_valid) popped.push_back(tx_data);
    bus(32'h00030000, 1'b1, 8'h00); if (tx_valid) popped.push_back(tx_data);
    bus(32'h00030000, 1'b1, 8'h21); if (tx_valid) popped.push_back(tx_data);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (tx_valid) popped.push_back(tx_data);
    end
    chk("hi_count", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("hi_0", {24'h0, popped[0]}, 32'h48);
      chk("hi_1", {24'h0, popped[1]}, 32'h69);
      chk("hi_2", {24'h0, popped[2]}, 32'h21);
    end

    // Fill, near-full flag, push+pop while full, overflow
    do_reset();
    tx_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      bus(32'h00030000, 1'b1, 8'(8'h10 + k));
      chk($sformatf("iobf_after_%0d", k), {31'h0, io_buffer_full}, (k >= 7) ? 32'h1 : 32'h0);
    end
    chk("ovf_at_full", {31'h0, txq_ovf}, 32'h0);
    tx_ready = 1'b1;
    bus(32'h00030000, 1'b1, 8'h77);
    tx_ready = 1'b0;
    chk("pushpop_no_ovf", {31'h0, txq_ovf}, 32'h0);
    chk("pushpop_head", {24'h0, tx_data}, 32'h12);
    chk("pushpop_iobf", {31'h0, io_buffer_full}, 32'h1);
    bus(32'h00030000, 1'b1, 8'hEE);
    chk("ovf_set", {31'h0, txq_ovf}, 32'h1);
    exp_q = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h77};
    tx_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("drain_%0d", j), {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, exp_q[j]});
      tick();
    end
    chk("drain_empty", {31'h0, tx_valid}, 32'h0);
    chk("ovf_sticky", {31'h0, txq_ovf}, 32'h1);

    // Stop flag with slow drain
    do_reset();
    tx_ready = 1'b0;
    bus(32'h00030000, 1'b1, 8'h41);
    bus(32'h00030000, 1'b1, 8'h42);
    bus(32'h00030000, 1'b1, 8'h43);
    bus(32'h00030004, 1'b1, 8'h00);
    chk("stop_no_early_done", {31'h0, prog_done}, 32'h0);
    idx_empty = -1; idx_done = -1; pulses = 0;
    popped.delete();
    for (int i = 0; i < 30; i++) begin
      tx_ready = ((i % 2) == 1);
      if (tx_valid && tx_ready) popped.push_back(tx_data);
      tick();
      if (!tx_valid && idx_empty < 0) idx_empty = i;
      if (prog_done) begin
        pulses++;
        if (idx_done < 0) idx_done = i;
      end
    end
    bus(32'h00030004, 1'b1, 8'h00);
    if (prog_done) pulses++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (prog_done) pulses++;
    end
    chk("done_pulses", pulses, 1);
    chk("done_timing", idx_done, idx_empty + 1);
    chk("stop_pop_count", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("stop_pop_0", {24'h0, popped[0]}, 32'h41);
      chk("stop_pop_2", {24'h0, popped[2]}, 32'h43);
    end

    // Async reset in the middle of a drain
    do_reset();
    tx_ready = 1'b0;
    for (int k = 0; k < 9; k++) bus(32'h00030000, 1'b1, 8'hC0);
    rx_valid = 1'b1; rx_data = 8'h5A;
    tick();
    rx_valid = 1'b0;
    bus(32'h00030000, 1'b0, 8'h00);
    bus(32'h00030004, 1'b1, 8'h00);
    chk("pre_arst_ovf", {31'h0, txq_ovf}, 32'h1);
    chk("pre_arst_din", {24'h0, mem_din}, 32'h5A);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("arst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("arst_iobf", {31'h0, io_buffer_full}, 32'h0);
    chk("arst_ovf", {31'h0, txq_ovf}, 32'h0);
    chk("arst_din", {24'h0, mem_din}, 32'h0);
    chk("arst_prog_done", {31'h0, prog_done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tx_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (prog_done) pulses++;
    end
    chk("arst_no_done", pulses, 0);
    chk("arst_still_empty", {31'h0, tx_valid}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Far end of the CPU's byte-wide memory bus (mem_a / mem_dout / mem_wr / mem_din / io_buffer_full).
- Services RAM reads and writes, and decodes the I/O window (mem_a[17:16]==2'b11).
- In that window it provides a UART-TX FIFO, a single-byte RX holding register, a cycle counter and a program-stop flag.
- Sits beside the cpu under the system top and replaces the behavioural RAM/HCI model in simulation and on FPGA.

Parameters:
RAM_AW, 17, RAM byte-address width (128 KB array, mem_a[16:0]).
TXQ_DEPTH, 8, UART TX FIFO entries (power of 2, >=4).
TXQ_AW, 3, log2(TXQ_DEPTH).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rdy  in  1  global ready; when low, all state freezes and bus accesses are ignored
mem_a  in  32  byte address from cpu; only [17:0] decoded
mem_dout  in  8  write data from cpu
mem_wr  in  1  1 = write, 0 = read
mem_din  out  8  read data to cpu, valid the cycle after the address
io_buffer_full  out  1  TX FIFO nearly full
tx_valid  out  1  TX FIFO head valid
tx_data  out  8  TX FIFO head byte
tx_ready  in  1  UART accepted the head this cycle
rx_valid  in  1  new input byte strobe
rx_data  in  8  input byte
prog_done  out  1  one-cycle pulse: stop requested and TX FIFO drained
txq_ovf  out  1  sticky; a TX push was dropped because the FIFO was full

Behaviour:
- Reset values: mem_din=0, io_buffer_full=0, tx_valid=0, tx_data=0, prog_done=0, txq_ovf=0; FIFO empty; cycle counter=0; rx register empty; stop flag=0.
- RAM contents are not reset.
- All register updates are gated by rdy. Reset overrides rdy.
- Decode: io = (mem_a[17:16]==2'b11). Otherwise the access targets RAM[mem_a[RAM_AW-1:0]].
- RAM write (mem_wr=1, !io): byte stored at the clock edge. No acknowledge; the next access may follow immediately.
- RAM read (mem_wr=0, !io): mem_din <= RAM[a] at the edge, so data is visible in cycle N+1. A read in N+1 of a byte written in N returns the new value.
- IO write 0x30000: if data != 0 and FIFO not full, push. If data != 0 and FIFO full, drop and set txq_ovf. Data 0x00 is ignored.
- IO write 0x30004: set stop flag; no data stored.
- IO read 0x30000: mem_din <= rx byte if rx register is full, else 0x00. A full register is cleared on that read.
- rx_valid with the register already full overwrites the byte.
- rx_valid in the same cycle as a read of 0x30000: the read returns the old contents (0 if empty), then the new byte is stored.
- IO read 0x30004..0x30007: returns byte lane (a[1:0]) of a snapshot.
  - Snapshot is taken at the read of 0x30004 (lane 0) and holds the counter value before that cycle's increment.
  - Lanes 1..3 read the held snapshot.
- Other IO addresses read 0x00; writes to them are ignored.
- Cycle counter: 32-bit, +1 each rdy cycle, wraps at 0xFFFFFFFF->0.
- TX FIFO:
  - tx_valid = !empty; tx_data = head.
  - Pop when tx_valid && tx_ready.
  - Simultaneous push and pop when full: the pop frees the slot and the push succeeds; no overflow.
  - Pointers are TXQ_AW bits; count is TXQ_AW+1 bits.
- io_buffer_full = (count >= TXQ_DEPTH-1), registered from next-count. This leaves one slot of slack for the write already in flight when the cpu samples the flag.
- Stop FSM: IDLE -> (stop write) DRAIN -> (FIFO empty and no push this cycle) DONE, which asserts prog_done for one cycle -> HALT.
  - HALT is sticky until reset. Further stop writes are ignored.
  - TX draining continues in every state.
- rdy low mid-operation: a read issued before rdy fell keeps mem_din held. FSM, counter and FIFO are frozen. tx_ready is ignored and no pop occurs.
- Async reset mid-drain: returns to IDLE and empties the FIFO; the in-flight byte is lost.

Decomposition:
- Shared package header gets: IO_BASE (18'h30000), IO_UART_OFF (0), IO_CLK_OFF (4), the stop-FSM state encodings, and BYTE_TP.
- One natural sub-module: sync_fifo (byte-wide, parameterised depth, count output), reused later by memctrl.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 next cycle -> mem_din=0xA5 one cycle later. Write-then-immediate-read of 0x1FFFF returns the new byte.
- Push 'H','i',0x00,'!' to 0x30000 with tx_ready=1 -> tx_data sequence 0x48,0x69,0x21; the 0x00 never appears.
- tx_ready=0, write 8 nonzero bytes -> io_buffer_full rises after the 7th push. The 9th write sets txq_ovf=1 and the FIFO holds the first 8 bytes. A push plus pop while full causes no overflow.
- After 100 rdy cycles from reset, read 0x30004..0x30007 -> lanes assemble 0x00000064 (snapshot value); held with rdy=0 for 10 cycles -> value unchanged.
- rx_valid with 0x37, then read 0x30000 twice -> 0x37, then 0x00.
- Queue 3 bytes, write 0x30004, grant tx_ready every 2nd cycle -> prog_done pulses exactly once, the cycle after the FIFO empties. Apply async rst during DRAIN -> all outputs reset immediately, and prog_done does not pulse.
